io_send_sys_trigger: RTL
========================

// Module: io_send_sys_trigger
// PURPOSE
//  Initiator side of the system-trigger handshake. Sequences NUM_RCV trigger receivers through reset -> mark -> go.
//  Collects their outputComplete lines, optionally repeats the shot REPS times with a fixed inter-shot gap, and flags a timeout.
//  Sits between host control registers and the bank of receiver channels (TX/ADC trigger receivers).
// PARAMETERS
//  NUM_RCV    8   number of receiver channels driven/collected
//  CNT_W      32  width of gap, timeout and repetition counters
// PORTS
//  clk             in   1        system clock; single clock domain
//  rst             in   1        asynchronous, active-low reset
//  arm             in   1        1-cycle pulse from host: start a sequence (ignored unless IDLE/DONE/FAULT)
//  abort           in   1        1-cycle pulse: return to IDLE from any state, receivers held in reset
//  extTrigEn       in   1        1 = GO waits for rising edge of extTrig; 0 = GO issued immediately after MARK
//  extTrig         in   1        external trigger, already synchronous to clk
//  rcvEnable       in   NUM_RCV  mask of channels taking part; sampled on arm
//  reps            in   CNT_W    shots per sequence; 0 treated as 1; sampled on arm
//  gapCycles       in   CNT_W    idle cycles between completion of one shot and next receiver reset
//  timeoutCycles   in   CNT_W    max cycles in WAIT_CMPL; 0 = no timeout
//  rcvComplete     in   NUM_RCV  outputComplete lines from receivers
//  rcvReset        out  1        active-high reset to all receivers
//  onYourMark      out  1        to all receivers
//  GOGOGO_EXCLAMATION out 1      to all receivers
//  busy            out  1        high outside IDLE/DONE/FAULT
//  seqDone         out  1        1-cycle pulse when the last shot completes
//  timedOut        out  1        sticky; cleared by arm or abort
//  shotCount       out  CNT_W    shots completed in current sequence
//  missingMask     out  NUM_RCV  enabled channels not complete at timeout (sticky, cleared by arm)
// BEHAVIOUR
//  Reset (rst=0): state IDLE; rcvReset=1; onYourMark=0; GOGOGO_EXCLAMATION=0; busy=0; seqDone=0; timedOut=0; shotCount=0; missingMask=0.
//  All outputs registered; arm -> rcvReset pulse begins next cycle.
//  States:
//   IDLE       rcvReset=1. arm -> RCV_RST (latch rcvEnable, reps, clear counters/flags).
//   RCV_RST    rcvReset=1 for exactly 1 cycle -> SETTLE.
//   SETTLE     rcvReset=0 for 2 cycles, so receivers clear outputComplete -> MARK.
//   MARK       onYourMark=1 for 1 cycle -> GO if !extTrigEn, else ARMED.
//   ARMED      onYourMark=1 held; extTrig rising edge (prev 0, now 1) -> GO.
//   GO         onYourMark=1, GOGOGO_EXCLAMATION=1 for exactly 1 cycle -> WAIT_CMPL; timeout counter loaded.
//   WAIT_CMPL  marks low; done when (rcvComplete & enMask)==enMask.
//              - enMask==0: done immediately.
//              - done: shotCount++; if shotCount+1>=reps -> DONE with seqDone pulse, else GAP.
//              - timeout counter hits 0 (timeoutCycles!=0): timedOut=1, missingMask=enMask&~rcvComplete -> FAULT.
//              - done and timeout in same cycle: done wins.
//   GAP        count gapCycles (0 = skip) -> RCV_RST.
//   DONE/FAULT rcvReset=0 (complete lines stay readable). arm -> RCV_RST.
//  abort in any state -> IDLE next cycle, marks dropped same edge. arm ignored that cycle; abort has priority over arm.
//  arm while busy: ignored.
//  Counters are unsigned, no wrap: shotCount saturates at all-ones.
//  Async reset mid-sequence: immediate return to reset values; receivers see rcvReset=1 asynchronously.
// STRUCTURE
//  Package io_sys_trig_pkg: state enum (IDLE, RCV_RST, SETTLE, MARK, ARMED, GO, WAIT_CMPL, GAP, DONE, FAULT), SETTLE_CYCLES=2.
//  Sub-module io_trig_down_counter (load/enable/zero flag, width CNT_W), instanced for gap and timeout.
// TESTING
//  1. reps=1, rcvEnable=8'h0F, extTrigEn=0, complete ch0-3 5 cycles after GO -> one rcvReset, one mark/go pair, seqDone, shotCount=1.
//  2. reps=3, gapCycles=10 -> 3 GO pulses, each GO preceded by >=12 cycles from previous completion; seqDone once; shotCount=3.
//  3. extTrigEn=1, extTrig held high at entry then low->high at +20 -> GO only after the rising edge; onYourMark high throughout ARMED.
//  4. timeoutCycles=50, ch2 never completes -> FAULT at GO+51, timedOut=1, missingMask=8'h04, no seqDone.
//  5. abort during WAIT_CMPL, and rst pulse during GAP -> IDLE, rcvReset=1, marks low next edge / immediately.
//  6. rcvEnable=0 -> each shot completes the cycle after GO; arm pulsed while busy is ignored.

Source files
------------

// File: rtl/io_sys_trig_pkg.sv
// Shared types and constants for the system-trigger initiator.
//   state_e      : sequencer states (idle, receiver reset, settle, mark, armed, go,
//                  wait-for-complete, inter-shot gap, done, fault)
//   SettleCycles : cycles rcvReset is held low before onYourMark is raised
//   is_busy()    : true for every state except idle/done/fault
package io_sys_trig_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StRcvRst,
        StSettle,
        StMark,
        StArmed,
        StGo,
        StWaitCmpl,
        StGap,
        StDone,
        StFault
    } state_e;

    localparam int unsigned SettleCycles = 2;

    function automatic logic is_busy(state_e s);
        return !(s inside {StIdle, StDone, StFault});
    endfunction

endpackage

// File: rtl/io_trig_down_counter.sv
// Loadable saturating down counter.
//   clk, rst  : clock, asynchronous active-low reset (count clears to 0)
//   load      : load load_val this cycle (wins over en)
//   load_val  : value to load
//   en        : decrement by one, holding at zero
//   zero      : count is currently zero
module io_trig_down_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/io_send_sys_trigger.sv
// Initiator side of the system-trigger handshake: walks NUM_RCV receivers through
// reset -> mark -> go, collects their complete lines, repeats for reps shots with a
// gap between them, and flags a timeout with the set of missing channels.
//   clk, rst            : clock, asynchronous active-low reset
//   arm, abort          : host start / return-to-idle pulses (abort wins)
//   extTrigEn, extTrig  : gate GO on a rising edge of extTrig when enabled
//   rcvEnable, reps     : channel mask and shot count, captured on arm
//   gapCycles           : idle cycles between a completed shot and the next reset
//   timeoutCycles       : max cycles waiting for completion (0 = none)
//   rcvComplete         : receivers' outputComplete lines
//   rcvReset, onYourMark, GOGOGO_EXCLAMATION : broadcast receiver controls
//   busy, seqDone, timedOut, shotCount, missingMask : status to the host
module io_send_sys_trigger
    import io_sys_trig_pkg::*;
#(
    parameter int unsigned NUM_RCV = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               abort,
    input  logic               extTrigEn,
    input  logic               extTrig,
    input  logic [NUM_RCV-1:0] rcvEnable,
    input  logic [CNT_W-1:0]   reps,
    input  logic [CNT_W-1:0]   gapCycles,
    input  logic [CNT_W-1:0]   timeoutCycles,
    input  logic [NUM_RCV-1:0] rcvComplete,
    output logic               rcvReset,
    output logic               onYourMark,
    output logic               GOGOGO_EXCLAMATION,
    output logic               busy,
    output logic               seqDone,
    output logic               timedOut,
    output logic [CNT_W-1:0]   shotCount,
    output logic [NUM_RCV-1:0] missingMask
);

    state_e             state_q, state_d;
    logic [NUM_RCV-1:0] en_mask_q;
    logic [CNT_W-1:0]   reps_q;
    logic               ext_trig_q;
    logic               to_en_q;

    logic               wait_done;
    logic               last_shot;
    logic               ext_rise;
    logic [CNT_W:0]     next_shot;
    logic               gap_load;
    logic [CNT_W-1:0]   gap_load_val;
    logic               gap_zero;
    logic               to_zero;
    logic               start;

    assign wait_done = ((rcvComplete & en_mask_q) == en_mask_q);
    // One extra bit so the compare stays correct when shotCount is all-ones.
    assign next_shot = {1'b0, shotCount} + (CNT_W + 1)'(1);
    assign last_shot = (next_shot >= {1'b0, reps_q});
    assign ext_rise  = extTrig && !ext_trig_q;
    assign start     = (state_d == StRcvRst) && (state_q inside {StIdle, StDone, StFault});

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone, StFault: if (arm) state_d = StRcvRst;
                StRcvRst:                state_d = StSettle;
                StSettle:                if (gap_zero) state_d = StMark;
                StMark:                  state_d = extTrigEn ? StArmed : StGo;
                StArmed:                 if (ext_rise) state_d = StGo;
                StGo:                    state_d = StWaitCmpl;
                StWaitCmpl: begin
                    // Completion is checked first so it wins over a same-cycle timeout.
                    if (wait_done) begin
                        if (last_shot)              state_d = StDone;
                        else if (gapCycles == '0)   state_d = StRcvRst;
                        else                        state_d = StGap;
                    end else if (to_en_q && to_zero) begin
                        state_d = StFault;
                    end
                end
                StGap:                   if (gap_zero) state_d = StRcvRst;
                default:                 state_d = StIdle;
            endcase
        end
    end

    // The gap counter also times the settle phase; both load "cycles - 1" and exit on zero.
    always_comb begin
        gap_load     = 1'b0;
        gap_load_val = '0;
        if (state_q == StRcvRst && state_d == StSettle) begin
            gap_load     = 1'b1;
            gap_load_val = CNT_W'(SettleCycles - 1);
        end else if (state_q == StWaitCmpl && state_d == StGap) begin
            gap_load     = 1'b1;
            gap_load_val = gapCycles - CNT_W'(1);
        end
    end

    io_trig_down_counter #(
        .CNT_W (CNT_W)
    ) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_load_val),
        .en       (state_q == StSettle || state_q == StGap),
        .zero     (gap_zero)
    );

    // Loaded on entry to GO so that it reaches zero after timeoutCycles cycles of waiting.
    io_trig_down_counter #(
        .CNT_W (CNT_W)
    ) u_to_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state_d == StGo),
        .load_val (timeoutCycles),
        .en       (state_q == StGo || state_q == StWaitCmpl),
        .zero     (to_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= StIdle;
            rcvReset           <= 1'b1;
            onYourMark         <= 1'b0;
            GOGOGO_EXCLAMATION <= 1'b0;
            busy               <= 1'b0;
            seqDone            <= 1'b0;
            timedOut           <= 1'b0;
            shotCount          <= '0;
            missingMask        <= '0;
            en_mask_q          <= '0;
            reps_q             <= '0;
            ext_trig_q         <= 1'b0;
            to_en_q            <= 1'b0;
        end else begin
            state_q            <= state_d;
            ext_trig_q         <= extTrig;
            // Outputs decode the next state so they change on the same edge as the state.
            rcvReset           <= (state_d inside {StIdle, StRcvRst});
            onYourMark         <= (state_d inside {StMark, StArmed, StGo});
            GOGOGO_EXCLAMATION <= (state_d == StGo);
            busy               <= is_busy(state_d);
            seqDone            <= (state_q == StWaitCmpl) && (state_d == StDone);

            if (state_d == StGo) begin
                to_en_q <= (timeoutCycles != '0);
            end

            if (start) begin
                en_mask_q   <= rcvEnable;
                reps_q      <= (reps == '0) ? CNT_W'(1) : reps;
                shotCount   <= '0;
                timedOut    <= 1'b0;
                missingMask <= '0;
            end else begin
                if (abort) begin
                    timedOut <= 1'b0;
                end
                if (state_q == StWaitCmpl && wait_done && !abort && shotCount != '1) begin
                    shotCount <= shotCount + CNT_W'(1);
                end
                if (state_q == StWaitCmpl && state_d == StFault) begin
                    timedOut    <= 1'b1;
                    missingMask <= en_mask_q & ~rcvComplete;
                end
            end
        end
    end

endmodule
